// File: rtl/mem_access_stage_pkg.sv
// Shared types and helpers for the MEM stage: access size encodings, FSM states,
// and the byte-lane / alignment helpers used for data memory accesses.
package mem_access_stage_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  // size is funct3[1:0]: log2 of the access width in bytes
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM inputs, stall back-pressure and the registered MEM/WB bundle of the MEM stage.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic            ex_mem_valid;
  logic            ex_mem_MemRead;
  logic            ex_mem_MemWrite;
  logic            ex_mem_MemtoReg;
  logic            ex_mem_RegWrite;
  logic [4:0]      ex_mem_rd;
  logic [2:0]      ex_mem_funct3;
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] ex_mem_store_data;

  logic            mem_stall;
  logic            mem_wb_valid;
  logic            mem_wb_RegWrite;
  logic            mem_wb_MemtoReg;
  logic [4:0]      mem_wb_rd;
  logic [XLEN-1:0] mem_wb_alu_result;
  logic [XLEN-1:0] mem_wb_mem_data;
  logic            mem_wb_misalign;

  modport master (
    output ex_mem_valid, ex_mem_MemRead, ex_mem_MemWrite, ex_mem_MemtoReg, ex_mem_RegWrite,
           ex_mem_rd, ex_mem_funct3, ex_mem_alu_result, ex_mem_store_data,
    input  mem_stall, mem_wb_valid, mem_wb_RegWrite, mem_wb_MemtoReg, mem_wb_rd,
           mem_wb_alu_result, mem_wb_mem_data, mem_wb_misalign
  );

  modport slave (
    input  ex_mem_valid, ex_mem_MemRead, ex_mem_MemWrite, ex_mem_MemtoReg, ex_mem_RegWrite,
           ex_mem_rd, ex_mem_funct3, ex_mem_alu_result, ex_mem_store_data,
    output mem_stall, mem_wb_valid, mem_wb_RegWrite, mem_wb_MemtoReg, mem_wb_rd,
           mem_wb_alu_result, mem_wb_mem_data, mem_wb_misalign
  );

endinterface

// File: rtl/mem_access_stage_data_mem.sv
// DEPTH x 64-bit data memory: combinational word read, byte-enabled synchronous write.
// Contents are deliberately not reset.
module data_mem #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic [7:0]               be,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [63:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [63:0]              rdata
);

  logic [63:0] mem [DEPTH];
  logic [63:0] old_word;
  logic [63:0] merged;

  assign rdata    = mem[raddr];
  assign old_word = mem[waddr];

  // Merge as a read-modify-write so the array has a single write port
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign merged[gi*8 +: 8] = be[gi] ? wdata[gi*8 +: 8] : old_word[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (|be) mem[waddr] <= merged;
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV64 MEM stage with MEM/WB register: lane steering, load extension, alignment
// check and a latency FSM that stalls upstream while an access is outstanding.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_stage_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            mem_op, is_load, is_store, misalign, retire, stall;
  logic [2:0]      offset;
  logic [1:0]      size;
  logic [AW-1:0]   widx;
  logic [7:0]      be;
  logic [63:0]     wdata, rword, shifted, load_ext;

  logic            wb_valid_reg, wb_regwrite_reg, wb_memtoreg_reg, wb_misalign_reg;
  logic [4:0]      wb_rd_reg;
  logic [XLEN-1:0] wb_alu_reg, wb_data_reg;

  assign mem_op   = bus.ex_mem_valid & (bus.ex_mem_MemRead | bus.ex_mem_MemWrite);
  assign is_store = mem_op & bus.ex_mem_MemWrite;
  assign is_load  = mem_op & ~bus.ex_mem_MemWrite;
  assign offset   = bus.ex_mem_alu_result[2:0];
  assign size     = bus.ex_mem_funct3[1:0];
  assign widx     = bus.ex_mem_alu_result[AW+2:3];
  assign misalign = misaligned(size, offset);

  assign be      = (retire & is_store & ~misalign & rst_n) ? lane_mask(size, offset) : 8'h00;
  assign wdata   = bus.ex_mem_store_data << {offset, 3'b000};
  assign shifted = rword >> {offset, 3'b000};

  data_mem #(.DEPTH(DEPTH)) u_data_mem (
    .clk   (clk),
    .be    (be),
    .waddr (widx),
    .wdata (wdata),
    .raddr (widx),
    .rdata (rword)
  );

  always_comb begin
    load_ext = shifted;
    case (bus.ex_mem_funct3)
      F3_B:    load_ext = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    load_ext = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_ext = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   load_ext = {56'd0, shifted[7:0]};
      F3_HU:   load_ext = {48'd0, shifted[15:0]};
      F3_WU:   load_ext = {32'd0, shifted[31:0]};
      F3_D:    load_ext = shifted;
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mem_op && MEM_LATENCY > 0) begin
          stall      = 1'b1;
          state_next = ST_WAIT;
          cnt_next   = CW'(MEM_LATENCY - 1);
        end else begin
          retire = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_reg != '0) begin
          stall    = 1'b1;
          cnt_next = cnt_reg - CW'(1);
        end else begin
          retire     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Stall is gated by reset so upstream is released as soon as reset asserts
  assign bus.mem_stall = stall & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_reg    <= 1'b0;
      wb_regwrite_reg <= 1'b0;
      wb_memtoreg_reg <= 1'b0;
      wb_misalign_reg <= 1'b0;
      wb_rd_reg       <= '0;
      wb_alu_reg      <= '0;
      wb_data_reg     <= '0;
    end else if (retire) begin
      wb_valid_reg    <= bus.ex_mem_valid;
      wb_regwrite_reg <= bus.ex_mem_valid & bus.ex_mem_RegWrite & (bus.ex_mem_rd != 5'd0)
                         & ~(mem_op & misalign);
      wb_memtoreg_reg <= bus.ex_mem_MemtoReg;
      wb_misalign_reg <= mem_op & misalign;
      wb_rd_reg       <= bus.ex_mem_rd;
      wb_alu_reg      <= bus.ex_mem_alu_result;
      wb_data_reg     <= (is_load & ~misalign) ? load_ext : '0;
    end else begin
      // Bubble while the access is outstanding
      wb_valid_reg    <= 1'b0;
      wb_regwrite_reg <= 1'b0;
      wb_misalign_reg <= 1'b0;
    end
  end

  assign bus.mem_wb_valid      = wb_valid_reg;
  assign bus.mem_wb_RegWrite   = wb_regwrite_reg;
  assign bus.mem_wb_MemtoReg   = wb_memtoreg_reg;
  assign bus.mem_wb_misalign   = wb_misalign_reg;
  assign bus.mem_wb_rd         = wb_rd_reg;
  assign bus.mem_wb_alu_result = wb_alu_reg;
  assign bus.mem_wb_mem_data   = wb_data_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: one instance with latency 2, one with latency 0 and a
// small depth for address wrap, both checked against a byte-array memory model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int DEPTH_A = 256;
  localparam int LAT_A   = 2;
  localparam int DEPTH_B = 16;
  localparam int LAT_B   = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage_if bus_a();
  mem_access_stage_if bus_b();

  mem_access_stage #(.DEPTH(DEPTH_A), .MEM_LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  mem_access_stage #(.DEPTH(DEPTH_B), .MEM_LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Shared stimulus; only the selected instance sees a valid slot
  logic        sel = 1'b0;
  logic        d_valid = 0, d_rd = 0, d_wr = 0, d_m2r = 0, d_rw = 0;
  logic [4:0]  d_rdst = 0;
  logic [2:0]  d_f3 = 0;
  logic [63:0] d_alu = 0, d_sd = 0;

  assign bus_a.ex_mem_valid      = d_valid & ~sel;
  assign bus_b.ex_mem_valid      = d_valid & sel;
  assign bus_a.ex_mem_MemRead    = d_rd;
  assign bus_b.ex_mem_MemRead    = d_rd;
  assign bus_a.ex_mem_MemWrite   = d_wr;
  assign bus_b.ex_mem_MemWrite   = d_wr;
  assign bus_a.ex_mem_MemtoReg   = d_m2r;
  assign bus_b.ex_mem_MemtoReg   = d_m2r;
  assign bus_a.ex_mem_RegWrite   = d_rw;
  assign bus_b.ex_mem_RegWrite   = d_rw;
  assign bus_a.ex_mem_rd         = d_rdst;
  assign bus_b.ex_mem_rd         = d_rdst;
  assign bus_a.ex_mem_funct3     = d_f3;
  assign bus_b.ex_mem_funct3     = d_f3;
  assign bus_a.ex_mem_alu_result = d_alu;
  assign bus_b.ex_mem_alu_result = d_alu;
  assign bus_a.ex_mem_store_data = d_sd;
  assign bus_b.ex_mem_store_data = d_sd;

  logic        o_stall, o_valid, o_rw, o_m2r, o_mis;
  logic [4:0]  o_rd;
  logic [63:0] o_alu, o_data;
  assign o_stall = sel ? bus_b.mem_stall         : bus_a.mem_stall;
  assign o_valid = sel ? bus_b.mem_wb_valid      : bus_a.mem_wb_valid;
  assign o_rw    = sel ? bus_b.mem_wb_RegWrite   : bus_a.mem_wb_RegWrite;
  assign o_m2r   = sel ? bus_b.mem_wb_MemtoReg   : bus_a.mem_wb_MemtoReg;
  assign o_mis   = sel ? bus_b.mem_wb_misalign   : bus_a.mem_wb_misalign;
  assign o_rd    = sel ? bus_b.mem_wb_rd         : bus_a.mem_wb_rd;
  assign o_alu   = sel ? bus_b.mem_wb_alu_result : bus_a.mem_wb_alu_result;
  assign o_data  = sel ? bus_b.mem_wb_mem_data   : bus_a.mem_wb_mem_data;

  // Byte-addressed reference memories
  logic [7:0] ref_a [DEPTH_A*8];
  logic [7:0] ref_b [DEPTH_B*8];

  int checks = 0;
  int errors = 0;
  int b_stall_cnt = 0;

  always @(negedge clk) begin
    if (bus_b.mem_stall) b_stall_cnt <= b_stall_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_rd(input int a);
    return sel ? ref_b[a] : ref_a[a];
  endfunction

  task automatic ref_wr(input int a, input logic [7:0] v);
    if (sel) ref_b[a] = v;
    else     ref_a[a] = v;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one slot (entry: just after a rising edge), waits for its retirement,
  // checks the MEM/WB bundle and the stall count against the model.
  task automatic run_op(input string name, input logic v, input logic r, input logic w,
                        input logic m2r, input logic rw, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] sd);
    int lat, n, nb, base, stalls;
    logic memop, mis, is_ld;
    logic [63:0] ldval, exp_data;
    lat   = sel ? LAT_B : LAT_A;
    n     = sel ? DEPTH_B*8 : DEPTH_A*8;
    nb    = 1 << f3[1:0];
    base  = int'(alu & 64'(n - 1));
    memop = v & (r | w);
    mis   = (alu[2:0] & 3'(nb - 1)) != 3'd0;
    is_ld = memop & ~w;
    ldval = '0;
    if (is_ld && !mis) begin
      for (int i = 0; i < nb; i++) ldval[8*i +: 8] = ref_rd((base + i) % n);
      if (!f3[2] && nb < 8 && ldval[8*nb-1]) ldval = ldval | (~64'd0 << (8*nb));
    end
    exp_data = (is_ld && !mis) ? ldval : 64'd0;

    d_valid = v; d_rd = r; d_wr = w; d_m2r = m2r; d_rw = rw;
    d_rdst = rd; d_f3 = f3; d_alu = alu; d_sd = sd;

    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!o_stall) break;
      if (stalls > 0) begin
        check({name, "_bubble_valid"}, 64'(o_valid), 64'd0);
        check({name, "_bubble_rw"}, 64'(o_rw), 64'd0);
      end
      stalls++;
      @(posedge clk);
    end
    @(posedge clk);
    #1;

    check({name, "_stalls"}, 64'(stalls), memop ? 64'(lat) : 64'd0);
    check({name, "_valid"}, 64'(o_valid), 64'(v));
    check({name, "_regwrite"}, 64'(o_rw), 64'(v & rw & (rd != 5'd0) & ~(memop & mis)));
    check({name, "_memtoreg"}, 64'(o_m2r), 64'(m2r));
    check({name, "_rd"}, 64'(o_rd), 64'(rd));
    check({name, "_alu"}, o_alu, alu);
    check({name, "_data"}, o_data, exp_data);
    check({name, "_misalign"}, 64'(o_mis), 64'(memop & mis));

    if (memop && w && !mis)
      for (int i = 0; i < nb; i++) ref_wr((base + i) % n, sd[8*i +: 8]);

    $display("dut%0d %-6s v=%0d r=%0d w=%0d f3=%0d addr=%h sd=%h -> stalls=%0d rw=%0d mis=%0d data=%h",
             sel, name, v, r, w, f3, alu, sd, stalls, o_rw, o_mis, o_data);
  endtask

  logic [63:0] word_b;
  logic [63:0] rnd_alu, rnd_sd;
  int kind, nbr, wsel, off, aw;
  logic [2:0] rf3;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl_a", {54'd0, bus_a.mem_stall, bus_a.mem_wb_valid, bus_a.mem_wb_RegWrite,
          bus_a.mem_wb_MemtoReg, bus_a.mem_wb_misalign, bus_a.mem_wb_rd}, 64'd0);
    check("reset_alu_a", bus_a.mem_wb_alu_result, 64'd0);
    check("reset_data_a", bus_a.mem_wb_mem_data, 64'd0);
    check("reset_ctrl_b", {54'd0, bus_b.mem_stall, bus_b.mem_wb_valid, bus_b.mem_wb_RegWrite,
          bus_b.mem_wb_MemtoReg, bus_b.mem_wb_misalign, bus_b.mem_wb_rd}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency-2 instance: directed sequence
    sel = 1'b0;
    run_op("SD",  1, 0, 1, 0, 0, 5'd0, F3_D,  64'h40, 64'h1122334455667788);
    run_op("LD",  1, 1, 0, 1, 1, 5'd5, F3_D,  64'h40, 64'd0);
    check("ld_word", o_data, 64'h1122334455667788);
    run_op("SB",  1, 0, 1, 0, 0, 5'd0, F3_B,  64'h43, 64'h123456789ABCDEFF);
    run_op("LD",  1, 1, 0, 1, 1, 5'd6, F3_D,  64'h40, 64'd0);
    check("word_after_sb", o_data, 64'h11223344FF667788);
    run_op("LB",  1, 1, 0, 1, 1, 5'd8, F3_B,  64'h43, 64'd0);
    check("lb_sext", o_data, 64'hFFFFFFFFFFFFFFFF);
    run_op("LBU", 1, 1, 0, 1, 1, 5'd9, F3_BU, 64'h43, 64'd0);
    check("lbu_zext", o_data, 64'h00000000000000FF);
    run_op("LWmis", 1, 1, 0, 1, 1, 5'd7, F3_W, 64'h42, 64'd0);
    check("lw_mis_flag", 64'(o_mis), 64'd1);
    run_op("NOP", 0, 0, 0, 0, 1, 5'd3, F3_D, 64'h42, 64'd0);
    run_op("SWmis", 1, 0, 1, 0, 0, 5'd0, F3_W, 64'h46, 64'hCAFEBABE0BADF00D);
    run_op("LD",  1, 1, 0, 1, 1, 5'd5, F3_D,  64'h40, 64'd0);
    check("word_after_swmis", o_data, 64'h11223344FF667788);
    run_op("ADD", 1, 0, 0, 0, 1, 5'd10, F3_B, 64'd100, 64'd0);
    run_op("ADD0", 1, 0, 0, 0, 1, 5'd0, F3_B, 64'd100, 64'd0);

    // Reset while the access is waiting: the store must be dropped
    d_valid = 1; d_rd = 0; d_wr = 1; d_m2r = 0; d_rw = 0; d_rdst = 5'd0;
    d_f3 = F3_D; d_alu = 64'h40; d_sd = 64'hDEADBEEFDEADBEEF;
    @(posedge clk);
    #1;
    check("pre_reset_stall", 64'(o_stall), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midwait_reset_ctrl", {54'd0, o_stall, o_valid, o_rw, o_m2r, o_mis, o_rd}, 64'd0);
    check("midwait_reset_alu", o_alu, 64'd0);
    check("midwait_reset_data", o_data, 64'd0);
    $display("dut%0d RESET  asserted mid-wait stall=%0d valid=%0d", sel, o_stall, o_valid);
    d_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("LD",  1, 1, 0, 1, 1, 5'd5, F3_D,  64'h40, 64'd0);
    check("word_after_reset", o_data, 64'h11223344FF667788);

    // Latency-0 instance with 16 words: wrap and single-cycle accesses
    sel = 1'b1;
    word_b = {$urandom, $urandom};
    run_op("SD",  1, 0, 1, 0, 0, 5'd0, F3_D, 64'h40, word_b);
    run_op("LD",  1, 1, 0, 1, 1, 5'd4, F3_D, 64'h40, 64'd0);
    check("b_ld", o_data, word_b);
    run_op("LDwrap", 1, 1, 0, 1, 1, 5'd4, F3_D, 64'(64'h40 + 8*DEPTH_B), 64'd0);
    check("b_ld_wrap", o_data, word_b);

    // Randomized phase on both instances
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      aw  = sel ? 4 : 8;
      for (int w = 0; w < 16; w++)
        run_op("init", 1, 0, 1, 0, 0, 5'd0, F3_D, 64'(w * 8), {$urandom, $urandom});
      for (int t = 0; t < 60; t++) begin
        kind = $urandom_range(0, 3);
        rf3  = (kind == 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
        nbr  = 1 << rf3[1:0];
        wsel = $urandom_range(0, 15);
        off  = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) off = off & ~(nbr - 1);
        rnd_alu = ({$urandom, $urandom} << (3 + aw)) | 64'(wsel * 8) | 64'(off);
        rnd_sd  = {$urandom, $urandom};
        case (kind)
          0: run_op("rld", 1, 1, 0, 1, 1'($urandom_range(0, 1)), 5'($urandom), rf3, rnd_alu, rnd_sd);
          1: run_op("rst", 1, 0, 1, 0, 0, 5'($urandom), rf3, rnd_alu, rnd_sd);
          2: run_op("ralu", 1, 0, 0, 0, 1'($urandom_range(0, 1)), 5'($urandom), rf3, rnd_alu, rnd_sd);
          default: run_op("rmix", 1'($urandom_range(0, 1)), 1, 1, 0, 1, 5'($urandom), rf3, rnd_alu, rnd_sd);
        endcase
      end
    end

    check("b_never_stalled", 64'(b_stall_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage plus MEM/WB register. Sits between the EX/MEM register and the writeback stage.
- Performs RV64 loads and stores against an internal byte-addressed data memory with configurable access latency.
- Stalls upstream while an access is outstanding.
- Drives the registered mem_wb_* bundle that the writeback stage consumes.

Parameters:
- DEPTH, 256, number of 64-bit words in data memory (power of two).
- MEM_LATENCY, 2, stall cycles inserted per load/store (0 = single-cycle access).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_mem_valid  in  1  EX/MEM slot holds a real instruction.
- ex_mem_MemRead  in  1  load.
- ex_mem_MemWrite  in  1  store.
- ex_mem_MemtoReg  in  1  writeback selects memory data.
- ex_mem_RegWrite  in  1  instruction writes rd.
- ex_mem_rd  in  5  destination register.
- ex_mem_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- ex_mem_alu_result  in  64  effective address or ALU value.
- ex_mem_store_data  in  64  rs2 value for stores.
- mem_stall  out  1  upstream must hold EX/MEM contents stable.
- mem_wb_valid  out  1  registered valid.
- mem_wb_RegWrite  out  1  registered.
- mem_wb_MemtoReg  out  1  registered.
- mem_wb_rd  out  5  registered.
- mem_wb_alu_result  out  64  registered passthrough.
- mem_wb_mem_data  out  64  registered, extended load data.
- mem_wb_misalign  out  1  one-cycle flag: the retired access was misaligned.

Behaviour:
- Reset (rst_n low, async): FSM to IDLE, counter 0, all mem_wb_* outputs 0, mem_stall 0. Memory contents are not reset. A pending store is dropped.
- FSM states: IDLE, WAIT.
- Memory op = ex_mem_valid & (MemRead | MemWrite). A slot with both MemRead and MemWrite is treated as a store.
- IDLE, no memory op: retire at the next edge. The mem_wb_* regs capture the inputs; mem_wb_mem_data = 0.
- IDLE, memory op, MEM_LATENCY=0: retire at the next edge. mem_stall stays 0.
- IDLE, memory op, MEM_LATENCY>0:
  - mem_stall=1 combinationally.
  - Next state WAIT, cnt=MEM_LATENCY-1.
  - mem_wb_valid and mem_wb_RegWrite go 0 at that edge (bubble).
- WAIT, cnt!=0: mem_stall=1, cnt decrements, bubble stays in mem_wb.
- WAIT, cnt==0: mem_stall=0. The op retires at this edge and the FSM returns to IDLE.
- Stall count: mem_stall is high for exactly MEM_LATENCY cycles per memory op. The op is visible on mem_wb_* MEM_LATENCY+1 edges after first presentation.
- Upstream contract: inputs are stable while mem_stall=1. The block uses the values sampled at retirement.
- Addressing: little-endian. Word index = alu_result[log2(DEPTH)+2:3]. Higher address bits are ignored (wrap). Byte offset = alu_result[2:0].
- Alignment: H needs offset[0]=0, W needs offset[1:0]=0, D needs offset=0.
- Store retirement: the byte lanes selected by size/offset are written exactly once, at the retiring edge. Other lanes are unchanged.
- Load retirement: bytes are read from the memory state before the retiring edge. They are sign-extended (B/H/W) or zero-extended (BU/HU/WU/D) to 64 bits into mem_wb_mem_data.
- Back-to-back store then load to the same address: the load returns the stored data.
- Misaligned access, at retirement:
  - Store is suppressed.
  - mem_wb_mem_data = 0.
  - mem_wb_RegWrite forced 0.
  - mem_wb_misalign=1 for one cycle.
  - The full latency is still consumed.
- Invalid slot (ex_mem_valid=0): no memory access. mem_wb_valid=0 and mem_wb_RegWrite=0 at the next edge.
- mem_wb_RegWrite is forced 0 when rd=0.
- mem_wb_misalign is 0 on every non-retiring cycle.

Decomposition:
- Shared package holds:
  - funct3 size encodings (F3_B..F3_WU);
  - FSM state enum (ST_IDLE, ST_WAIT);
  - XLEN=64.
- One sub-module, data_mem:
  - DEPTH x 64 array;
  - combinational word read;
  - synchronous write with 8-bit byte-enable.
- The stage does lane steering, extension, alignment check, FSM and the MEM/WB register.

Test Plan:
- Reset mid-WAIT: present SD, drop rst_n after 1 stall cycle. Required: all outputs 0 immediately, FSM IDLE, memory word unchanged.
- MEM_LATENCY=2: SD 0x1122334455667788 at addr 0x40, then LD from 0x40, rd=5. Required: mem_stall high 2 cycles per op; LD retires with mem_wb_mem_data=0x1122334455667788, mem_wb_rd=5.
- SB 0xFF at addr 0x43 over that word, then LB 0x43 and LBU 0x43. Required: word=0x11223344FF667788; LB=0xFFFFFFFFFFFFFFFF; LBU=0x00000000000000FF.
- LW at 0x42 (misaligned) with RegWrite=1, rd=7. Required: mem_wb_misalign=1 one cycle, mem_wb_RegWrite=0, mem_wb_mem_data=0. SW at 0x46 leaves memory unchanged.
- ADD result 100, rd=10, no memory op. Required: no stall; next edge mem_wb_alu_result=100, RegWrite=1, MemtoReg=0. Same with rd=0: RegWrite=0.
- MEM_LATENCY=0: LD at 0x40 and at 0x40+8*DEPTH (wraps). Required: both retire in 1 cycle with identical data, mem_stall never asserted.
